// File: rtl/timer_bank.sv
// Multi-channel memory-mapped timer bank with shared prescaler, per-channel
// one-shot/auto-reload counting and write-1-to-clear interrupt status.
module timer_bank #(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PRESCALE  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0100
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        pc_31,
  output logic        irq
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] TL_MAX  = {WIDTH{1'b1}};
  localparam logic [1:0] REG_TH   = 2'd0;
  localparam logic [1:0] REG_TL   = 2'd1;
  localparam logic [1:0] REG_TCON = 2'd2;

  logic [PS_W-1:0]  ps_cnt;
  logic             tick;
  logic [WIDTH-1:0] th [N_CH];
  logic [WIDTH-1:0] tl [N_CH];
  logic [N_CH-1:0]  en, ie, st, os;

  logic             hit;
  logic [3:0]       ch_sel;
  logic [1:0]       reg_sel;
  logic [WIDTH-1:0] wval;
  logic [N_CH-1:0]  th_we, tl_we, tcon_we;
  logic [N_CH-1:0]  count_en, ovf, os_next;
  logic             unused_addr_bits;

  assign hit              = (addr[31:8] == BASE_ADDR[31:8]);
  assign ch_sel           = addr[7:4];
  assign reg_sel          = addr[3:2];
  assign wval             = wdata[WIDTH-1:0];
  assign tick             = (ps_cnt == PS_LAST);
  assign unused_addr_bits = ^addr[1:0];

  // Per-channel write strobes; channels at or above N_CH never match.
  always_comb begin
    th_we   = '0;
    tl_we   = '0;
    tcon_we = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (wr && hit && (ch_sel == 4'(i))) begin
        case (reg_sel)
          REG_TH:   th_we[i]   = 1'b1;
          REG_TL:   tl_we[i]   = 1'b1;
          REG_TCON: tcon_we[i] = 1'b1;
          default:  ;
        endcase
      end
    end
  end

  // A TCON write that clears EN suppresses the tick on the same edge.
  always_comb begin
    count_en = '0;
    ovf      = '0;
    os_next  = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      count_en[i] = tick && en[i] && !(tcon_we[i] && !wdata[0]);
      ovf[i]      = count_en[i] && (tl[i] == TL_MAX);
      os_next[i]  = tcon_we[i] ? wdata[3] : os[i];
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      ps_cnt <= '0;
      en     <= '0;
      ie     <= '0;
      st     <= '0;
      os     <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        th[i] <= '0;
        tl[i] <= '0;
      end
    end else begin
      ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
      for (int i = 0; i < int'(N_CH); i++) begin
        if (th_we[i]) th[i] <= wval;

        // Software write beats reload; reload uses the pre-write TH.
        if (tl_we[i])         tl[i] <= wval;
        else if (ovf[i])      tl[i] <= th[i];
        else if (count_en[i]) tl[i] <= tl[i] + WIDTH'(1);

        if (tcon_we[i]) begin
          en[i] <= wdata[0];
          ie[i] <= wdata[1];
          os[i] <= wdata[3];
        end
        if (ovf[i] && os_next[i]) en[i] <= 1'b0;

        // New overflow status takes priority over a simultaneous clear.
        if (ovf[i] && ie[i])               st[i] <= 1'b1;
        else if (tcon_we[i] && wdata[2])   st[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rd && hit) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        if (ch_sel == 4'(i)) begin
          case (reg_sel)
            REG_TH:   rdata = 32'(th[i]);
            REG_TL:   rdata = 32'(tl[i]);
            REG_TCON: rdata = {28'd0, os[i], st[i], ie[i], en[i]};
            default:  rdata = '0;
          endcase
        end
      end
    end
  end

  assign irq = (|(st & ie)) & ~pc_31;

endmodule
